// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer
//
// Core-side trap/return sequencer. Takes interrupts from the interrupt
// controller at instruction boundaries, takes synchronous exceptions at any
// time, and executes MRET. Each accepted event runs a fixed three-step
// sequence:
//   accept (IDLE) -> SAVE or RESTORE strobe -> REDIRECT -> IDLE
// SAVE writes mepc/mcause/mtval and stacks MIE in the CSR unit.
// RESTORE unstacks MIE.
// REDIRECT loads the trap vector (or mepc) into the PC.
// After every redirect a short holdoff blocks new interrupts but not
// exceptions, so the handler's first instruction can issue.
//
// Parameters
//   VEC_CAUSES      vectored-mode interrupts with cause[4:0] < VEC_CAUSES jump
//                   to base + 4*cause; every other trap jumps to base
//   HOLDOFF_CYCLES  IDLE cycles after a redirect during which interrupts
//                   are not accepted (0 = no holdoff)
//
// Optional build macro
//   TRAP_COUNTERS_EN  adds saturating int_count / exc_count outputs
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   interrupt_req      pending enabled interrupt
//   interrupt_cause    mcause for that interrupt (bit31 = 1)
//   instr_boundary     an instruction retires this cycle, next_pc valid
//   next_pc            PC of the next instruction to execute
//   exc_req            synchronous exception on the current instruction
//   exc_cause          exception mcause (bit31 = 0)
//   exc_pc             PC of the faulting instruction
//   exc_tval           exception mtval
//   mret_req           MRET retiring this cycle
//   mtvec, mepc        current CSR values
//   trap_save          one-cycle CSR save strobe
//   mepc_wdata         saved PC (held until the next capture)
//   mcause_wdata       saved cause (held until the next capture)
//   mtval_wdata        saved tval (held until the next capture)
//   mret_restore       one-cycle CSR restore strobe
//   flush              kill in-flight instructions
//   stall              hold fetch/issue (high in every non-IDLE state)
//   pc_redirect        one-cycle PC load strobe
//   redirect_pc        PC load target
//   int_ack            one-cycle: interrupt taken
//   int_count          (TRAP_COUNTERS_EN) interrupts taken
//   exc_count          (TRAP_COUNTERS_EN) exceptions taken
// ---------------------------------------------------------------------------
module trap_sequencer #(
  parameter int VEC_CAUSES     = 16,
  parameter int HOLDOFF_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        interrupt_req,
  input  logic [31:0] interrupt_cause,
  input  logic        instr_boundary,
  input  logic [31:0] next_pc,
  input  logic        exc_req,
  input  logic [31:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        trap_save,
  output logic [31:0] mepc_wdata,
  output logic [31:0] mcause_wdata,
  output logic [31:0] mtval_wdata,
  output logic        mret_restore,
  output logic        flush,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        int_ack
`ifdef TRAP_COUNTERS_EN
  ,
  output logic [31:0] int_count,
  output logic [31:0] exc_count
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SAVE     = 2'd1;
  localparam logic [1:0] ST_RESTORE  = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  // The counter must hold HOLDOFF_CYCLES. Keep at least one bit so the
  // zero-holdoff build still has a legal (always-zero) register.
  localparam int HOLD_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam int unsigned VEC_LIMIT = VEC_CAUSES;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [HOLD_W-1:0] holdoff_cnt;

  logic [31:0] cap_cause;
  logic [31:0] cap_epc;
  logic [31:0] cap_tval;
  logic        cap_is_int;
  logic [31:0] target_pc;

  logic accept_exc;
  logic accept_mret;
  logic accept_int;

  logic [31:0] trap_base;
  logic        vec_hit;
  logic [31:0] trap_target;
  logic [31:0] mret_target;

  // mepc[1:0] is forced to zero in the return target and is otherwise unused.
  logic unused_mepc_bits;
  assign unused_mepc_bits = &{1'b0, mepc[1:0]};

  // Acceptance and next state. Exceptions beat MRET, and MRET beats
  // interrupts. Only the interrupt path looks at the holdoff counter and the
  // boundary qualifier. Requests are ignored outside IDLE.
  always_comb begin
    state_next  = state;
    accept_exc  = 1'b0;
    accept_mret = 1'b0;
    accept_int  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (exc_req) begin
          accept_exc = 1'b1;
          state_next = ST_SAVE;
        end else if (mret_req) begin
          accept_mret = 1'b1;
          state_next  = ST_RESTORE;
        end else if (interrupt_req && instr_boundary && (holdoff_cnt == '0)) begin
          accept_int = 1'b1;
          state_next = ST_SAVE;
        end
      end
      ST_SAVE:     state_next = ST_REDIRECT;
      ST_RESTORE:  state_next = ST_REDIRECT;
      ST_REDIRECT: state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Trap vector. Only mode 2'b01 vectors, and only interrupts (cause[31])
  // whose cause number is inside the vector table. Modes 2'b10 and 2'b11
  // fall back to direct.
  always_comb begin
    trap_base   = {mtvec[31:2], 2'b00};
    vec_hit     = (mtvec[1:0] == 2'b01) && cap_cause[31] &&
                  (32'(cap_cause[4:0]) < VEC_LIMIT);
    trap_target = vec_hit ? (trap_base + {25'd0, cap_cause[4:0], 2'b00})
                          : trap_base;
    mret_target = {mepc[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The counter reloads on every redirect and drains only while IDLE, so a
  // trap that is taken during the holdoff still gets a full holdoff after
  // its own redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdoff_cnt <= '0;
    end else if (state == ST_REDIRECT) begin
      holdoff_cnt <= HOLD_LOAD;
    end else if ((state == ST_IDLE) && (holdoff_cnt != '0)) begin
      holdoff_cnt <= holdoff_cnt - HOLD_ONE;
    end
  end

  // The capture registers drive the CSR write data directly. They keep their
  // value until the next trap is accepted. MRET only clears the interrupt
  // flag so the REDIRECT that follows it does not raise int_ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_cause  <= '0;
      cap_epc    <= '0;
      cap_tval   <= '0;
      cap_is_int <= 1'b0;
    end else if (accept_exc) begin
      cap_cause  <= exc_cause;
      cap_epc    <= exc_pc;
      cap_tval   <= exc_tval;
      cap_is_int <= 1'b0;
    end else if (accept_int) begin
      cap_cause  <= interrupt_cause;
      cap_epc    <= next_pc;
      cap_tval   <= '0;
      cap_is_int <= 1'b1;
    end else if (accept_mret) begin
      cap_is_int <= 1'b0;
    end
  end

  // The redirect target is latched in the cycle before REDIRECT. A trap uses
  // mtvec as seen during SAVE, and a return uses mepc as seen during RESTORE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_pc <= '0;
    end else if (state == ST_SAVE) begin
      target_pc <= trap_target;
    end else if (state == ST_RESTORE) begin
      target_pc <= mret_target;
    end
  end

  assign trap_save    = (state == ST_SAVE);
  assign mret_restore = (state == ST_RESTORE);
  assign flush        = (state == ST_SAVE) || (state == ST_RESTORE);
  assign stall        = (state != ST_IDLE);
  assign pc_redirect  = (state == ST_REDIRECT);
  assign int_ack      = (state == ST_REDIRECT) && cap_is_int;
  assign redirect_pc  = target_pc;
  assign mepc_wdata   = cap_epc;
  assign mcause_wdata = cap_cause;
  assign mtval_wdata  = cap_tval;

`ifdef TRAP_COUNTERS_EN
  // Interrupts are counted on int_ack. Exceptions are counted on their SAVE
  // strobe. A sequence cut short by reset is cleared along with the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_count <= '0;
      exc_count <= '0;
    end else begin
      if (int_ack && (int_count != 32'hFFFF_FFFF)) begin
        int_count <= int_count + 32'd1;
      end
      if (trap_save && !cap_is_int && (exc_count != 32'hFFFF_FFFF)) begin
        exc_count <= exc_count + 32'd1;
      end
    end
  end
`endif

endmodule
